sweep_range_sequencer: RTL and testbench
========================================

Name: sweep_range_sequencer

Overview:
Sequences one 7-angle range sweep (theta codes 0..6 = 0..90 deg in 15-deg steps) for the phone-home locator. For each angle it requests an (x,y) sample from the ultrasound/location front end over a req/valid handshake and converts it to range r in 4-inch units through an inverse-sine scaler. It writes r into a 7-entry range table and tracks the nearest target. Sits between the sensor interface and the display/targeting logic.

Parameters:
NUM_ANGLES, 7, angles per sweep; theta codes 0..NUM_ANGLES-1.
TIMEOUT_CYCLES, 1024, maximum WAIT cycles per sample before the angle is abandoned.
TW, 10, timeout counter width; must satisfy 2^TW >= TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle sweep start; ignored unless idle
sample_req  out  1  held high while a sample is requested for theta_out
theta_out  out  4  angle code being requested/processed
sample_valid  in  1  sample strobe; accepted only in WAIT
sample_x  in  8  x component, qualified by sample_valid
sample_y  in  8  y component, qualified by sample_valid
busy  out  1  high from the cycle after an accepted start through the DONE state
done  out  1  one-cycle pulse at sweep end
r_wr_en  out  1  range table write strobe
r_wr_addr  out  3  table index = theta code
r_wr_data  out  8  range value; 255 = invalid
min_r  out  8  smallest valid r in the current sweep
min_theta  out  4  theta code of min_r
err  out  1  sticky; set on any timeout, cleared by start

Behaviour:
- Reset (async, reset_n=0): state IDLE; every output 0, except min_r=255; theta counter and timeout counter cleared. Reset mid-sweep aborts the sweep with no done pulse and no further writes.
- FSM: IDLE -start-> REQ (theta=0, err=0, min_r=255, min_theta=0) -> WAIT -> CALC -> WRITE -> (theta<NUM_ANGLES-1 ? REQ with theta+1 : DONE) -> IDLE.
- REQ (1 cycle): assert sample_req; clear the timeout counter.
- WAIT: sample_req stays high. sample_valid=1 latches x and y, drops sample_req the next cycle, and moves to CALC. When the counter reaches TIMEOUT_CYCLES-1 without valid, set err, force r=255, and go to WRITE. Valid arriving on the timeout cycle counts as a valid sample.
- CALC (1 cycle, registered): r = x>>2 for theta 0; r = (y*K)>>10 for theta 1..5, with K = 989, 512, 362, 296, 265; r = y>>2 for theta 6. Use a 18-bit product and floor truncation. The maximum result, 246, always fits in 8 bits.
- WRITE (1 cycle): r_wr_en=1, r_wr_addr=theta, r_wr_data=r. If r != 255 and r < min_r (strict), update min_r and min_theta. Ties keep the lower theta.
- DONE (1 cycle): done=1; busy falls with the return to IDLE.
- Latency per angle without timeout: 4 cycles plus the sample wait. A sweep with same-cycle valid takes 7*4+1 cycles.
- sample_valid outside WAIT and start outside IDLE are ignored. theta_out holds its value from REQ through WRITE.

Optional Feature:
SWEEP_AVG2_EN
- Defined: each angle takes two handshakes (REQ/WAIT twice). x and y become floor((s1+s2)/2) using 9-bit sums. A timeout on either sample invalidates the angle (r=255).
- Undefined: one sample per angle, as above.

Decomposition:
- Package sweep_pkg holds: theta code localparams (TH_0..TH_90), K constant table, shift amount 10, R_INVALID=255, and state encodings.
- One sub-module, inv_sin_scaler: combinational theta/x/y -> r per the CALC rule. The sequencer registers its output in CALC.

Test Plan:
1. Every sample x=80, y=100 with immediate valid -> writes addr0..6 = 20, 96, 50, 35, 28, 25, 25; min_r=20, min_theta=0; done pulses once; err=0.
2. x=0, y=255 for all angles -> addr0=0, addr1=246, addr6=63; min_r=0, min_theta=0.
3. No valid at theta 3 -> after 1024 WAIT cycles write 255 to addr3; err=1; sweep continues; that angle is excluded from the min.
4. x=100, y=100 -> theta0 and theta5 both give 25; min_theta=0 (tie keeps the lower code). A start pulse mid-sweep changes nothing.
5. reset_n low during theta-2 WAIT -> outputs zero immediately, min_r=255, no done. A new start sweeps cleanly from theta 0.
6. SWEEP_AVG2_EN: y samples 100 then 101 at theta 2 -> y=100, r=50; two sample_req pulses per angle.

Source files
------------

// File: rtl/sweep_pkg.sv
// sweep_pkg: theta codes, inverse-sine scale constants and FSM encoding for the range sweep
package sweep_pkg;

    localparam logic [3:0] TH_0  = 4'd0;
    localparam logic [3:0] TH_15 = 4'd1;
    localparam logic [3:0] TH_30 = 4'd2;
    localparam logic [3:0] TH_45 = 4'd3;
    localparam logic [3:0] TH_60 = 4'd4;
    localparam logic [3:0] TH_75 = 4'd5;
    localparam logic [3:0] TH_90 = 4'd6;

    localparam logic [9:0] K_15 = 10'd989;
    localparam logic [9:0] K_30 = 10'd512;
    localparam logic [9:0] K_45 = 10'd362;
    localparam logic [9:0] K_60 = 10'd296;
    localparam logic [9:0] K_75 = 10'd265;

    localparam int SHIFT = 10;

    localparam logic [7:0] R_INVALID = 8'd255;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CALC, S_WRITE, S_DONE} state_t;

    function automatic logic [9:0] k_of(input logic [3:0] theta);
        return theta == TH_15 ? K_15 :
               theta == TH_30 ? K_30 :
               theta == TH_45 ? K_45 :
               theta == TH_60 ? K_60 :
               theta == TH_75 ? K_75 : 10'd0;
    endfunction

endpackage

// File: rtl/inv_sin_scaler.sv
// inv_sin_scaler: combinational (theta, x, y) -> range in 4-inch units, floor-truncated
module inv_sin_scaler
    import sweep_pkg::*;
(
    input  logic [3:0] theta,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] r
);

    logic [17:0] prod;

    // 0 and 90 deg are plain shifts; intermediate angles scale y by 1024/(4*sin)
    always_comb begin
        prod = 18'(y) * 18'(k_of(theta));
        r = theta == TH_0 ? x >> 2 : theta == TH_90 ? y >> 2 : 8'(prod >> SHIFT);
    end

endmodule

// File: rtl/sweep_range_sequencer.sv
// sweep_range_sequencer: one 7-angle range sweep with sample handshake, range table writes and nearest-target tracking
// Optional build macro SWEEP_AVG2_EN: average two samples per angle.
module sweep_range_sequencer
    import sweep_pkg::*;
#(
    parameter int NUM_ANGLES     = 7,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TW             = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic       sample_req,
    output logic [3:0] theta_out,
    input  logic       sample_valid,
    input  logic [7:0] sample_x,
    input  logic [7:0] sample_y,
    output logic       busy,
    output logic       done,
    output logic       r_wr_en,
    output logic [2:0] r_wr_addr,
    output logic [7:0] r_wr_data,
    output logic [7:0] min_r,
    output logic [3:0] min_theta,
    output logic       err
);

    state_t state, next;
    logic [3:0] theta;
    logic [TW-1:0] cnt;
    logic [7:0] x_l, y_l, r, r_calc;
    logic timeout, last, pend;

    assign timeout = cnt == TW'(TIMEOUT_CYCLES - 1);
    assign last = theta == 4'(NUM_ANGLES - 1);

`ifdef SWEEP_AVG2_EN
    logic second;
    logic [7:0] x1, y1;
    assign pend = !second;
`else
    assign pend = 1'b0;
`endif

    assign sample_req = state == S_REQ || state == S_WAIT;
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;
    assign r_wr_en = state == S_WRITE;
    assign r_wr_addr = theta[2:0];
    assign r_wr_data = r;
    assign theta_out = theta;

    inv_sin_scaler u_scaler (
        .theta(theta),
        .x(x_l),
        .y(y_l),
        .r(r_calc)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= next;
    end

    // sweep sequencing: a first averaged sample loops back to REQ for the second one
    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = start ? S_REQ : S_IDLE;
            S_REQ:   next = S_WAIT;
            S_WAIT:  next = sample_valid ? (pend ? S_REQ : S_CALC) : timeout ? S_WRITE : S_WAIT;
            S_CALC:  next = S_WRITE;
            S_WRITE: next = last ? S_DONE : S_REQ;
            S_DONE:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // datapath: sample capture, timeout counting, range register and nearest-target tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            theta     <= '0;
            cnt       <= '0;
            x_l       <= '0;
            y_l       <= '0;
            r         <= '0;
            min_r     <= R_INVALID;
            min_theta <= '0;
            err       <= 1'b0;
`ifdef SWEEP_AVG2_EN
            second    <= 1'b0;
            x1        <= '0;
            y1        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    theta     <= '0;
                    err       <= 1'b0;
                    min_r     <= R_INVALID;
                    min_theta <= '0;
                end
                S_REQ: cnt <= '0;
                S_WAIT: if (sample_valid) begin
`ifdef SWEEP_AVG2_EN
                    if (second) begin
                        x_l <= 8'((9'(x1) + 9'(sample_x)) >> 1);
                        y_l <= 8'((9'(y1) + 9'(sample_y)) >> 1);
                    end else begin
                        x1 <= sample_x;
                        y1 <= sample_y;
                    end
                    second <= !second;
`else
                    x_l <= sample_x;
                    y_l <= sample_y;
`endif
                end else if (timeout) begin
                    err <= 1'b1;
                    r   <= R_INVALID;
`ifdef SWEEP_AVG2_EN
                    second <= 1'b0;
`endif
                end else begin
                    cnt <= cnt + TW'(1);
                end
                S_CALC: r <= r_calc;
                S_WRITE: begin
                    if (r != R_INVALID && r < min_r) begin
                        min_r     <= r;
                        min_theta <= theta;
                    end
                    if (!last) theta <= theta + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_range_sequencer.sv
// tb_sweep_range_sequencer: randomized sweeps scored against a queue-based reference model
module tb_sweep_range_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_x = '0;
    logic [7:0] sample_y = '0;
    logic       sample_req, busy, done, r_wr_en, err;
    logic [3:0] theta_out, min_theta;
    logic [2:0] r_wr_addr;
    logic [7:0] r_wr_data, min_r;

    sweep_range_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .sample_req(sample_req),
        .theta_out(theta_out),
        .sample_valid(sample_valid),
        .sample_x(sample_x),
        .sample_y(sample_y),
        .busy(busy),
        .done(done),
        .r_wr_en(r_wr_en),
        .r_wr_addr(r_wr_addr),
        .r_wr_data(r_wr_data),
        .min_r(min_r),
        .min_theta(min_theta),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int mr; int mt; int er; int len;} sw_t;

    wr_t wq[$];
    sw_t sq[$];
    int vectors = 0;
    int miscompares = 0;
    int busy_len = 0;
    int xs[7];
    int ys[7];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // range in 4-inch units: x/4 at 0 deg, y/(4 sin theta) elsewhere, with 1024/(4 sin) pre-rounded to K
    function automatic int model_r(input int a, input int x, input int y);
        int kt[7] = '{0, 989, 512, 362, 296, 265, 0};
        if (a == 0) return x / 4;
        if (a == 6) return y / 4;
        return (y * kt[a]) / 1024;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_sample_req"}, int'(sample_req), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_r_wr_en"}, int'(r_wr_en), 0);
        chk({tag, "_r_wr_data"}, int'(r_wr_data), 0);
        chk({tag, "_theta_out"}, int'(theta_out), 0);
        chk({tag, "_min_r"}, int'(min_r), 255);
        chk({tag, "_min_theta"}, int'(min_theta), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // monitor: pops expectations whenever the DUT writes the table or ends a sweep
    always @(negedge clk) begin
        wr_t w;
        sw_t s;
        if (!reset_n || !busy) busy_len = 0;
        else busy_len++;
        if (r_wr_en) begin
            chk("write_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("wr_addr", int'(r_wr_addr), w.addr);
                chk("wr_data", int'(r_wr_data), w.data);
            end
        end
        if (done) begin
            chk("done_expected", int'(sq.size() > 0), 1);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("min_r", int'(min_r), s.mr);
                chk("min_theta", int'(min_theta), s.mt);
                chk("err", int'(err), s.er);
                if (s.len != 0) chk("sweep_len", busy_len, s.len);
            end
        end
    end

    task automatic run_sweep(input int to_a, input int rst_a, input bit noise, input int dmax, input int len);
        int r[7];
        int mr, mt, n;
        mr = 255;
        mt = 0;
        for (int a = 0; a < 7; a++) r[a] = (a == to_a) ? 255 : model_r(a, xs[a], ys[a]);
        for (int a = 0; a < 7; a++) if (r[a] < mr) mr = r[a];
        for (int a = 6; a >= 0; a--) if (r[a] == mr && mr != 255) mt = a;
        for (int a = 0; a < 7; a++) if (rst_a < 0 || a < rst_a) wq.push_back('{addr: a, data: r[a]});
        if (rst_a < 0) sq.push_back('{mr: mr, mt: mt, er: int'(to_a >= 0), len: len});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int a = 0; a < 7; a++) begin
            n = 0;
            while (!sample_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("req_seen", int'(sample_req), 1);
            if (!sample_req) return;
            chk("theta_out", int'(theta_out), a);
            if (noise) begin
                sample_valid = 1'($urandom_range(0, 1));
                sample_x = 8'($urandom);
                sample_y = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            sample_valid = 1'b0;
            start = 1'b0;
            if (a == rst_a) begin
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b0;
                #1;
                chk_reset("midreset");
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (a == to_a) begin
                n = 0;
                while (sample_req && n < 1100) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_cycles", n, 1024);
            end else begin
                repeat ($urandom_range(0, dmax)) @(negedge clk);
                sample_valid = 1'b1;
                sample_x = 8'(xs[a]);
                sample_y = 8'(ys[a]);
                @(negedge clk);
                sample_valid = 1'b0;
                if (noise) begin
                    sample_x = 8'($urandom);
                    sample_y = 8'($urandom);
                end
            end
        end
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_drop", int'(busy), 0);
    endtask

    task automatic fill(input int x, input int y);
        for (int a = 0; a < 7; a++) begin
            xs[a] = x;
            ys[a] = y;
        end
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 7; a++) begin
            xs[a] = $urandom_range(0, 255);
            ys[a] = $urandom_range(0, 255);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        @(negedge clk);
        fill(80, 100);
        run_sweep(-1, -1, 1'b0, 0, 29);
        fill(0, 255);
        run_sweep(-1, -1, 1'b0, 2, 0);
        fill(80, 100);
        run_sweep(3, -1, 1'b0, 2, 0);
        fill(100, 100);
        run_sweep(-1, -1, 1'b1, 3, 0);
        fill_rand();
        run_sweep(-1, 2, 1'b0, 0, 0);
        fill_rand();
        run_sweep(-1, -1, 1'b0, 0, 29);
        for (int i = 0; i < 20; i++) begin
            fill_rand();
            run_sweep(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1, -1, 1'($urandom_range(0, 1)), 3, 0);
        end
        repeat (5) @(negedge clk);
        chk("write_queue_drained", wq.size(), 0);
        chk("sweep_queue_drained", sq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
